fsmc_reg_slave: RTL and testbench

- Downstream consumer of one chip-select line of the FSMC bus interface.
- Decodes the latched bus address and maps MCU writes into a control register bank.
- Serves MCU reads from that bank, a status input, and a stream FIFO.
- The FIFO buffers samples from a fabric producer until the MCU pops them through a fixed data address.
- One instance per cs bit. Its bus_rdata drives the interface's per-module write-data slot.

---
 rtl/fsmc_reg_slave.sv | 185 ++++++++++++++++++
 tb/tb_fsmc_reg_slave.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsmc_reg_slave.sv
`default_nettype none
// ============================================================================
// fsmc_reg_slave : FSMC chip-select slave with RW register bank and stream FIFO
// Rev 1.0
// ============================================================================
module fsmc_reg_slave #(
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    NUM_REGS     = 8,
  parameter int                    FIFO_DEPTH   = 16,
  parameter logic [DATA_WIDTH-1:0] STATUS_ADDR  = 16'h00F0,
  parameter logic [DATA_WIDTH-1:0] LEVEL_ADDR   = 16'h00F1,
  parameter logic [DATA_WIDTH-1:0] FIFO_ADDR    = 16'h00F2,
  parameter logic [DATA_WIDTH-1:0] UNMAPPED_VAL = 16'hDEAD
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           cs_sel,
  input  logic                           addr_en,
  input  logic                           rd_en,
  input  logic                           wr_en,
  input  logic [DATA_WIDTH-1:0]          bus_wdata,
  output logic [DATA_WIDTH-1:0]          bus_rdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_regs,
  output logic [NUM_REGS-1:0]            reg_wr_pulse,
  input  logic [DATA_WIDTH-1:0]          status_in,
  input  logic [DATA_WIDTH-1:0]          stream_data,
  input  logic                           stream_valid,
  output logic                           stream_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int PAD_W = DATA_WIDTH - 1 - CNT_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_READ = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic                  addr_en_q, wr_en_q;
  logic                  prefetch_q, prefetch_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   pulse_q, pulse_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic                  addr_fall, wr_rise, wr_fall, addr_is_reg, push, pop;
  logic [IDX_W-1:0]      reg_idx;
  logic [DATA_WIDTH-1:0] fetch_val;

  assign addr_fall    = addr_en_q & ~addr_en;
  assign wr_rise      = ~wr_en_q & wr_en;
  assign wr_fall      = wr_en_q & ~wr_en;
  assign addr_is_reg  = (addr_q < DATA_WIDTH'(NUM_REGS));
  assign reg_idx      = addr_q[IDX_W-1:0];
  assign stream_ready = (count_q < CNT_W'(FIFO_DEPTH));
  assign push         = stream_valid & stream_ready;

  // Read source for the prefetch; an empty FIFO reads as zero.
  always_comb begin
    fetch_val = UNMAPPED_VAL;
    if (addr_is_reg)                fetch_val = regs_q[reg_idx];
    else if (addr_q == STATUS_ADDR) fetch_val = status_in;
    else if (addr_q == LEVEL_ADDR)  fetch_val = {underflow_q, {PAD_W{1'b0}}, count_q};
    else if (addr_q == FIFO_ADDR)   fetch_val = (count_q != '0) ? mem_q[head_q] : '0;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    prefetch_d  = 1'b0;
    rdata_d     = prefetch_q ? fetch_val : rdata_q;
    regs_d      = regs_q;
    pulse_d     = '0;
    underflow_d = underflow_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (addr_fall && cs_sel) begin
          state_d    = S_ADDR;
          addr_d     = bus_wdata;
          prefetch_d = 1'b1;
        end
      end
      S_ADDR: begin
        if (addr_fall) begin
          if (cs_sel) begin
            addr_d     = bus_wdata;
            prefetch_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (rd_en) begin
          if (addr_is_reg) begin
            regs_d[reg_idx]  = bus_wdata;
            pulse_d[reg_idx] = 1'b1;
          end
          state_d = S_IDLE;
        end else if (wr_rise) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        // A new address phase here abandons the read without side effects.
        if (addr_fall) begin
          if (cs_sel) begin
            state_d    = S_ADDR;
            addr_d     = bus_wdata;
            prefetch_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (wr_fall) begin
          if (addr_q == FIFO_ADDR) begin
            if (count_q != '0) pop = 1'b1;
            else               underflow_d = 1'b1;
          end else if (addr_q == LEVEL_ADDR) begin
            underflow_d = 1'b0;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    head_d = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d = push ? tail_q + PTR_W'(1) : tail_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      addr_en_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      prefetch_q  <= 1'b0;
      rdata_q     <= '0;
      pulse_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      addr_en_q   <= addr_en;
      wr_en_q     <= wr_en;
      prefetch_q  <= prefetch_d;
      rdata_q     <= rdata_d;
      pulse_q     <= pulse_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
      regs_q      <= regs_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= stream_data;
  end

  assign bus_rdata    = rdata_q;
  assign reg_wr_pulse = pulse_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign ctrl_regs[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

endmodule
`default_nettype wire

// File: tb/tb_fsmc_reg_slave.sv
`default_nettype none
// tb_fsmc_reg_slave: directed + randomized bench against a transaction-level model
// Rev 1.0
module tb_fsmc_reg_slave;

  logic         clk = 1'b0;
  logic         reset_n, cs_sel, addr_en, rd_en, wr_en, stream_valid, stream_ready;
  logic [15:0]  bus_wdata, bus_rdata, status_in, stream_data;
  logic [127:0] ctrl_regs;
  logic [7:0]   reg_wr_pulse;

  always #5 clk = ~clk;

  fsmc_reg_slave dut (
    .clk(clk), .reset_n(reset_n), .cs_sel(cs_sel), .addr_en(addr_en),
    .rd_en(rd_en), .wr_en(wr_en), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .ctrl_regs(ctrl_regs), .reg_wr_pulse(reg_wr_pulse), .status_in(status_in),
    .stream_data(stream_data), .stream_valid(stream_valid), .stream_ready(stream_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 0, rnd_stream = 0;
  int push_thr = 1;

  // transaction flags, each valid for exactly the next clock edge
  bit          m_prefetch = 0, m_write = 0, m_complete = 0;
  logic [15:0] m_paddr, m_waddr, m_wdata, m_caddr;

  // abstract model state
  logic [15:0]  mregs [8];
  logic [15:0]  q [$];
  bit           uflow, m_can_push;
  logic [15:0]  exp_rdata;
  logic [7:0]   exp_pulse;
  logic [127:0] exp_flat;

  logic [15:0] v, r_a;
  bit          r_cs;

  function automatic logic [15:0] decode(input logic [15:0] a);
    if (a < 16'd8)      return mregs[a[2:0]];
    if (a == 16'h00F0)  return status_in;
    if (a == 16'h00F1)  return {uflow, 10'b0, 5'(q.size())};
    if (a == 16'h00F2)  return (q.size() > 0) ? q[0] : 16'h0000;
    return 16'hDEAD;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    chk(name, {112'b0, act}, {112'b0, exp});
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {127'b0, act}, {127'b0, exp});
  endtask

  // model: applies the transaction-level effects scheduled for this edge
  initial forever begin
    @(posedge clk);
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
      q.delete();
      uflow     = 1'b0;
      exp_rdata = 16'h0;
      exp_pulse = 8'h0;
    end else begin
      m_can_push = (q.size() < 16);
      exp_pulse  = 8'h0;
      if (m_prefetch) exp_rdata = decode(m_paddr);
      if (m_write && m_waddr < 16'd8) begin
        mregs[m_waddr[2:0]]     = m_wdata;
        exp_pulse[m_waddr[2:0]] = 1'b1;
      end
      if (m_complete) begin
        if (m_caddr == 16'h00F2) begin
          if (q.size() > 0) void'(q.pop_front());
          else              uflow = 1'b1;
        end else if (m_caddr == 16'h00F1) begin
          uflow = 1'b0;
        end
      end
      if (stream_valid && m_can_push) q.push_back(stream_data);
    end
  end

  // per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (checking) begin
      for (int i = 0; i < 8; i++) exp_flat[i*16 +: 16] = mregs[i];
      chk("ctrl_regs", ctrl_regs, exp_flat);
      chk("reg_wr_pulse", {120'b0, reg_wr_pulse}, {120'b0, exp_pulse});
      chk16("bus_rdata", bus_rdata, exp_rdata);
      chk1("stream_ready", stream_ready, q.size() < 16);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    m_prefetch = 0;
    m_write    = 0;
    m_complete = 0;
    if (rnd_stream) begin
      stream_valid = ($urandom_range(0, 31) < push_thr);
      stream_data  = 16'($urandom);
      status_in    = 16'($urandom);
    end
  endtask

  task automatic bus_write(input bit cs, input logic [15:0] a, input logic [15:0] d);
    addr_en = 1; cs_sel = cs; bus_wdata = a;
    tick();
    addr_en = 0;
    tick();
    rd_en = 1; bus_wdata = d;
    m_prefetch = cs; m_paddr = a;
    m_write = cs; m_waddr = a; m_wdata = d;
    tick();
    rd_en = 0;
  endtask

  task automatic bus_read(input bit cs, input logic [15:0] a, input int hold, input bit pre,
                          input logic [15:0] pa, input bit push_fall, input logic [15:0] pdata,
                          output logic [15:0] val);
    cs_sel = cs;
    if (pre) begin
      addr_en = 1; bus_wdata = pa;
      tick();
      addr_en = 0;
      tick();
      m_prefetch = cs; m_paddr = pa;
    end
    addr_en = 1; bus_wdata = a;
    tick();
    addr_en = 0;
    tick();
    wr_en = 1; m_prefetch = cs; m_paddr = a;
    tick();
    @(negedge clk);
    val = bus_rdata;
    repeat (hold) tick();
    wr_en = 0; m_complete = cs; m_caddr = a;
    if (push_fall) begin stream_valid = 1; stream_data = pdata; end
    tick();
    if (push_fall) stream_valid = 0;
    @(negedge clk);
  endtask

  task automatic push_words(input logic [15:0] base, input int n);
    stream_valid = 1;
    for (int i = 0; i < n; i++) begin
      stream_data = base + 16'(i);
      tick();
    end
    stream_valid = 0;
  endtask

  function automatic logic [15:0] pick_addr();
    int s;
    s = $urandom_range(0, 12);
    if (s < 8) return 16'(s);
    case (s)
      8:       return 16'h00F0;
      9:       return 16'h00F1;
      12:      return 16'($urandom);
      default: return 16'h00F2;
    endcase
  endfunction

  initial begin
    reset_n = 0; cs_sel = 0; addr_en = 0; rd_en = 0; wr_en = 0;
    bus_wdata = 0; status_in = 16'h5A5A; stream_data = 0; stream_valid = 0;
    repeat (3) tick();
    reset_n  = 1;
    checking = 1;
    @(negedge clk);
    chk16("rst_bus_rdata", bus_rdata, 16'h0000);
    chk("rst_pulse", {120'b0, reg_wr_pulse}, 128'h0);
    chk("rst_regs", ctrl_regs, 128'h0);
    chk1("rst_ready", stream_ready, 1'b1);

    bus_write(1, 16'd3, 16'h1234);
    @(negedge clk);
    chk("wr_pulse", {120'b0, reg_wr_pulse}, 128'h08);
    chk("wr_regs", ctrl_regs, 128'h1234 << 48);
    tick();
    @(negedge clk);
    chk("wr_pulse_end", {120'b0, reg_wr_pulse}, 128'h0);

    bus_read(1, 16'd3, 2, 0, 16'h0, 0, 16'h0, v);
    chk16("rd_reg3", v, 16'h1234);
    bus_read(1, 16'h0055, 1, 0, 16'h0, 0, 16'h0, v);
    chk16("rd_unmapped", v, 16'hDEAD);

    // fill to full
    stream_valid = 1;
    for (int i = 0; i < 16; i++) begin
      stream_data = 16'hA000 + 16'(i);
      tick();
      if (i == 14) begin
        @(negedge clk);
        chk1("ready_before_full", stream_ready, 1'b1);
      end
    end
    stream_valid = 0;
    @(negedge clk);
    chk1("ready_full", stream_ready, 1'b0);
    bus_read(1, 16'h00F1, 0, 0, 16'h0, 0, 16'h0, v);
    chk16("level_full", v, 16'h0010);
    for (int i = 0; i < 16; i++) begin
      bus_read(1, 16'h00F2, 0, 0, 16'h0, 0, 16'h0, v);
      chk16("pop_a", v, 16'hA000 + 16'(i));
      if (i == 0) chk1("ready_after_pop", stream_ready, 1'b1);
    end

    // empty pop sets sticky underflow, cleared by a level read
    bus_read(1, 16'h00F2, 1, 0, 16'h0, 0, 16'h0, v);
    chk16("empty_pop", v, 16'h0000);
    bus_read(1, 16'h00F1, 0, 0, 16'h0, 0, 16'h0, v);
    chk16("level_uflow", v, 16'h8000);
    bus_read(1, 16'h00F1, 0, 0, 16'h0, 0, 16'h0, v);
    chk16("level_cleared", v, 16'h0000);

    // move pointers to 12, then straddle the wrap with count 5
    push_words(16'hC000, 12);
    for (int i = 0; i < 12; i++) begin
      bus_read(1, 16'h00F2, 0, 0, 16'h0, 0, 16'h0, v);
      chk16("pop_c", v, 16'hC000 + 16'(i));
    end
    push_words(16'hB000, 5);
    bus_read(1, 16'h00F1, 0, 0, 16'h0, 0, 16'h0, v);
    chk16("level_5", v, 16'h0005);
    bus_read(1, 16'h00F2, 0, 0, 16'h0, 1, 16'hB005, v);
    chk16("pushpop_data", v, 16'hB000);
    bus_read(1, 16'h00F1, 0, 0, 16'h0, 0, 16'h0, v);
    chk16("pushpop_level", v, 16'h0005);
    for (int i = 0; i < 5; i++) begin
      bus_read(1, 16'h00F2, 0, 0, 16'h0, 0, 16'h0, v);
      chk16("pop_wrap", v, 16'hB001 + 16'(i));
    end

    // address phase without cs: write ignored
    bus_write(0, 16'd2, 16'hBEEF);
    @(negedge clk);
    chk("cs0_regs", ctrl_regs, 128'h1234 << 48);
    chk("cs0_pulse", {120'b0, reg_wr_pulse}, 128'h0);

    // reset while in READ on the FIFO address
    push_words(16'hD000, 3);
    cs_sel = 1; addr_en = 1; bus_wdata = 16'h00F2;
    tick();
    addr_en = 0;
    tick();
    wr_en = 1; m_prefetch = 1; m_paddr = 16'h00F2;
    tick();
    tick();
    reset_n = 0; wr_en = 0;
    tick();
    reset_n = 1;
    @(negedge clk);
    chk1("abort_ready", stream_ready, 1'b1);
    chk16("abort_rdata", bus_rdata, 16'h0000);
    chk("abort_regs", ctrl_regs, 128'h0);
    bus_read(1, 16'h00F1, 0, 0, 16'h0, 0, 16'h0, v);
    chk16("abort_level", v, 16'h0000);

    // randomized traffic
    rnd_stream = 1;
    for (int n = 0; n < 400; n++) begin
      push_thr = (n < 200) ? 1 : 8;
      r_cs = ($urandom_range(0, 7) != 0);
      r_a  = pick_addr();
      if ($urandom_range(0, 2) == 0)
        bus_write(r_cs, r_a, 16'($urandom));
      else
        bus_read(r_cs, r_a, int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                 pick_addr(), 1'b0, 16'h0, v);
      repeat ($urandom_range(0, 2)) tick();
    end
    rnd_stream   = 0;
    stream_valid = 0;
    repeat (3) tick();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
